// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle multiply/divide sequencer owning the HI/LO register pair
module md_sequencer #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        req,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MUL  = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_LAT - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sgn_q, sgn_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic [63:0]   prod_s, prod_u, mul_res;
   logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
   logic          q_neg, r_neg, div_zero;

   // Datapath on latched operands: product and sign-magnitude division, consumed only at commit
   always_comb begin
      prod_u   = {32'd0, a_q} * {32'd0, b_q};
      prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      mul_res  = sgn_q ? prod_s : prod_u;
      a_mag    = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
      b_mag    = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
      div_zero = (b_q == 32'd0);
      // Guard keeps the divider defined; a zero divisor never commits anyway
      b_safe   = div_zero ? 32'd1 : b_mag;
      q_mag    = a_mag / b_safe;
      r_mag    = a_mag % b_safe;
      // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself
      q_neg    = sgn_q & (a_q[31] ^ b_q[31]);
      r_neg    = sgn_q & a_q[31];
      quo      = q_neg ? (~q_mag + 32'd1) : q_mag;
      rem      = r_neg ? (~r_mag + 32'd1) : r_mag;
   end

   // Sequencer: accept from IDLE only, count down the fixed latency, commit HI/LO at zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && !req) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     a_d     = rs;
                     b_d     = rt;
                     sgn_d   = (op == OP_MULT);
                     cnt_d   = CNT_MUL;
                     state_d = S_MUL;
                     busy_d  = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d     = rs;
                     b_d     = rt;
                     sgn_d   = (op == OP_DIV);
                     cnt_d   = CNT_DIV;
                     state_d = S_DIV;
                     busy_d  = 1'b1;
                  end
                  OP_MTHI: hi_d = rs;
                  OP_MTLO: lo_d = rs;
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            // req is deliberately ignored here: the op already left E and must complete
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (state_q == S_MUL) begin
                  hi_d = mul_res[63:32];
                  lo_d = mul_res[31:0];
               end else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any in-flight op without commit
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, cycles from accepted mult/multu to HI/LO commit.
REQ-002 SHALL have parameter DIV_LAT, default 10, cycles from accepted div/divu to HI/LO commit.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage issue strobe for the op on `op`.
REQ-006 op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-007 rs  input  32  first operand (dividend or multiplicand; mthi/mtlo source).
REQ-008 rt  input  32  second operand (divisor or multiplier).
REQ-009 req  input  1  exception/interrupt flush from CP0; when high, the issuing instruction is cancelled.
REQ-010 busy  output  1  registered; high while a mult/div is in flight.
REQ-011 done  output  1  registered one-cycle pulse in the cycle after HI/LO commit.
REQ-012 hi  output  32  registered HI register.
REQ-013 lo  output  32  registered LO register.

Function
REQ-014 SHALL implement states IDLE, MUL and DIV, plus a down-counter of width clog2(max(MUL_LAT,DIV_LAT))+1.
REQ-015 SHALL accept an op only when start=1, req=0 and state=IDLE; start while busy SHALL be ignored (the hazard unit stalls issue).
REQ-016 On accepting mult/multu: latch operands, load counter with MUL_LAT-1, go to MUL, and assert busy from the next cycle.
REQ-017 On accepting div/divu: latch operands, load counter with DIV_LAT-1, go to DIV, and assert busy from the next cycle.
REQ-018 In MUL/DIV: decrement the counter each cycle; at counter=0, write hi/lo, return to IDLE, deassert busy and pulse done on the same edge.
REQ-019 Result timing: a mult accepted at edge N SHALL make hi/lo valid and busy low after edge N+MUL_LAT; div SHALL do the same after edge N+DIV_LAT.
REQ-020 mult SHALL compute the signed 64-bit product; multu SHALL compute the unsigned product; hi=[63:32], lo=[31:0].
REQ-021 div SHALL produce a signed quotient in lo, truncated toward zero, and the remainder in hi, with the sign of the dividend.
REQ-022 divu SHALL produce an unsigned quotient in lo and the remainder in hi.
REQ-023 A divisor of 0 SHALL run the full DIV_LAT and pulse done, but leave hi/lo unchanged.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-025 mthi/mtlo accepted under REQ-015 SHALL write rs to hi/lo on the same edge, with no busy and no done.
REQ-026 Ops 0 and 7 SHALL have no effect.
REQ-027 While busy, hi/lo SHALL hold their previous values until commit; no partial result is visible.
REQ-028 req asserted during MUL/DIV SHALL NOT abort the in-flight op: an instruction already past E SHALL complete.
REQ-029 req asserted together with start SHALL block acceptance; state, hi and lo SHALL be unchanged.
REQ-030 Operands SHALL be sampled only at acceptance; rs/rt changes during busy SHALL NOT affect the result.

Reset
REQ-031 reset=1 at an edge SHALL force: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0.
REQ-032 reset SHALL take priority over start, req and an in-flight op; mid-operation reset discards the op with no commit and no done.

Verification
REQ-033 mult rs=0xFFFFFFFE, rt=0x00000003 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle.
REQ-034 multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
REQ-035 div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu 7/0 -> hi/lo unchanged, done pulses.
REQ-036 mthi 0x12345678 with req=0 -> hi=0x12345678 next edge, busy stays 0; mtlo with req=1 -> lo unchanged.
REQ-037 div accepted; req pulsed at cycle 3 and start re-pulsed at cycle 4 -> result still commits at cycle 10, second start ignored.
REQ-038 reset at cycle 2 of a div -> all outputs 0 next edge, no done, new mult accepted immediately after.
